// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared state encoding, digit-enable patterns and blank glyph for seg_scan_arbiter
package seg_scan_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_DIG0 = 4'b0111;
    localparam logic [3:0] AN_DIG1 = 4'b1011;
    localparam logic [3:0] AN_DIG2 = 4'b1101;
    localparam logic [3:0] AN_DIG3 = 4'b1110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    function automatic logic [3:0] an_sel(input logic [1:0] idx);
        return idx == 2'd0 ? AN_DIG0 : idx == 2'd1 ? AN_DIG1 : idx == 2'd2 ? AN_DIG2 : AN_DIG3;
    endfunction
endpackage

// File: rtl/seg_scan_arbiter_hex.sv
// hex_to_seg7: hex nibble to active-low seven-segment glyph, seg[6]=g ... seg[0]=a
module hex_to_seg7 (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    always_comb begin
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            default: seg_o = 7'b0001110;
        endcase
    end
endmodule

// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: two-requester frame-granular display arbiter with 4-digit scan; SEG_SCAN_LZ_BLANK_EN blanks leading zeros
module seg_scan_arbiter
    import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  gnt,
    output logic        frame_tick,
    output logic [3:0]  AN,
    output logic [6:0]  seg
);
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic          last_q, last_d;
    logic [15:0]   lat_q, lat_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          slot, bnd, hold_done, lz;
    logic [3:0]    nib;
    logic [6:0]    glyph;

    always_comb begin
        slot = cnt_q == CW'(REFRESH_DIV - 1);
        bnd = slot && idx_q == 2'd3;
        cnt_d = slot ? '0 : cnt_q + 1'b1;
        idx_d = slot ? idx_q + 1'b1 : idx_q;
        hold_inc = hold_q == HW'(HOLD_FRAMES) ? hold_q : hold_q + 1'b1;
        hold_done = hold_inc >= HW'(HOLD_FRAMES);
        state_d = state_q;
        if (bnd) begin
            case (state_q)
                OWN0: state_d = !req[0] ? (req[1] ? OWN1 : IDLE) : (req[1] && hold_done) ? OWN1 : OWN0;
                OWN1: state_d = !req[1] ? (req[0] ? OWN0 : IDLE) : (req[0] && hold_done) ? OWN0 : OWN1;
                default: state_d = req == 2'b11 ? (last_q ? OWN0 : OWN1) : req[0] ? OWN0 : req[1] ? OWN1 : IDLE;
            endcase
        end
        hold_d = !bnd ? hold_q : (state_d != state_q || state_d == IDLE) ? '0 : hold_inc;
        last_d = state_d == OWN1 ? 1'b1 : state_d == OWN0 ? 1'b0 : last_q;
        lat_d = !bnd ? lat_q : state_d == OWN1 ? data1 : state_d == OWN0 ? data0 : lat_q;
        gnt_d = {state_d == OWN1, state_d == OWN0};
    end

    // last_q=1 means requester 1 was granted last, so reset favours requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= IDLE;
            hold_q <= '0;
            last_q <= 1'b1;
            lat_q <= '0;
            gnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            state_q <= state_d;
            hold_q <= hold_d;
            last_q <= last_d;
            lat_q <= lat_d;
            gnt_q <= gnt_d;
        end
    end

    hex_to_seg7 u_hex (.hex_i(nib), .seg_o(glyph));

    always_comb begin
        nib = 4'(lat_q >> {~idx_q, 2'b00});
`ifdef SEG_SCAN_LZ_BLANK_EN
        lz = idx_q != 2'd3 && (lat_q >> {~idx_q, 2'b00}) == 16'd0;
`else
        lz = 1'b0;
`endif
        AN = state_q == IDLE ? AN_OFF : an_sel(idx_q);
        seg = (state_q == IDLE || lz) ? SEG_BLANK : glyph;
        frame_tick = bnd && !rst;
        gnt = gnt_q;
    end
endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb_seg_scan_arbiter: scoreboard bench with REFRESH_DIV=4, HOLD_FRAMES=2; honours SEG_SCAN_LZ_BLANK_EN
module tb_seg_scan_arbiter;
    localparam int DIV = 4;
    localparam int HOLD = 2;
    localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [1:0] gnt;
        logic       ft;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] data0 = '0, data1 = '0;
    logic [1:0]  gnt;
    logic        frame_tick;
    logic [3:0]  AN;
    logic [6:0]  seg;

    exp_t q[$];
    int checks = 0, fails = 0;
    int k, owner, held, last;
    logic [15:0] lat;

    always #5 clk = ~clk;

    seg_scan_arbiter #(.REFRESH_DIV(DIV), .HOLD_FRAMES(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .frame_tick(frame_tick), .AN(AN), .seg(seg)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int o, input logic [15:0] v, input int d);
        logic [3:0] n;
        n = v[4*(3-d) +: 4];
        if (o < 0) return 7'h7F;
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (d < 3 && (v >> (4*(3-d))) == 16'd0) return 7'h7F;
`endif
        return GLY[n];
    endfunction

    task automatic push_frame(input int from);
        exp_t e;
        for (int j = from; j < 16; j++) begin
            e.gnt = owner < 0 ? 2'b00 : owner == 0 ? 2'b01 : 2'b10;
            e.ft = j == 15;
            e.an = owner < 0 ? 4'hF : ~(4'b1000 >> (j / 4));
            e.seg = exp_seg(owner, lat, j / 4);
            q.push_back(e);
        end
    endtask

    task automatic model_boundary();
        int nxt, p;
        if (owner < 0) begin
            nxt = req == 2'b11 ? 1 - last : req == 2'b01 ? 0 : req == 2'b10 ? 1 : -1;
        end else begin
            p = 1 - owner;
            if (!req[owner]) nxt = req[p] ? p : -1;
            else if (req[p] && held + 1 >= HOLD) nxt = p;
            else nxt = owner;
        end
        if (nxt != owner) held = 0;
        else if (owner >= 0) held = (held + 1 > HOLD) ? HOLD : held + 1;
        owner = nxt;
        if (owner >= 0) begin
            last = owner;
            lat = owner == 1 ? data1 : data0;
        end
        push_frame(0);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        if (k % 16 == 15) model_boundary();
        k++;
        @(negedge clk);
        if (q.size() == 0) begin
            chk("queue_empty", 16'd0, 16'd1);
        end else begin
            e = q.pop_front();
            chk("gnt", 16'(gnt), 16'(e.gnt));
            chk("frame_tick", 16'(frame_tick), 16'(e.ft));
            chk("AN", 16'(AN), 16'(e.an));
            chk("seg", 16'(seg), 16'(e.seg));
        end
    endtask

    task automatic run_to(input int phase);
        step();
        while (k % 16 != phase) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 16'(gnt), 16'd0);
        chk("rst_ft", 16'(frame_tick), 16'd0);
        chk("rst_AN", 16'(AN), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        rst = 1'b0;
        q.delete();
        owner = -1;
        held = 0;
        last = 1;
        lat = '0;
        k = 0;
        push_frame(1);
    endtask

    initial begin
        do_reset();
        run_to(8);
        req = 2'b01;
        data0 = 16'h1234;
        run_to(8);
        data0 = 16'hABCD;
        run_to(8);
        run_to(8);
        req = 2'b00;
        run_to(8);
        run_to(8);
        do_reset();
        req = 2'b11;
        data0 = 16'h0F9E;
        data1 = 16'h5A6B;
        repeat (6) run_to(8);
        repeat (10) begin
            req = 2'($urandom);
            data0 = 16'($urandom);
            data1 = 16'($urandom);
            run_to($urandom_range(0, 15));
        end
        req = 2'b01;
        data0 = 16'h0005;
        run_to(8);
        run_to(8);
        run_to(8);
        data0 = 16'h0000;
        run_to(8);
        run_to(8);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_gnt", 16'(gnt), 16'd0);
        chk("midrst_ft", 16'(frame_tick), 16'd0);
        chk("midrst_AN", 16'(AN), 16'hF);
        chk("midrst_seg", 16'(seg), 16'h7F);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/seg_scan_arbiter.md
SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (min 2).
REQ-002 SHALL have parameter HOLD_FRAMES, default 8, minimum frames an owner keeps the display when contended (min 1).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  2  request, bit i for requester i.
REQ-006 SHALL have port data0  input  16  requester 0 value, four hex nibbles, [15:12] leftmost.
REQ-007 SHALL have port data1  input  16  requester 1 value, same layout.
REQ-008 SHALL have port gnt  output  2  registered one-hot grant, 00 when idle.
REQ-009 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.
REQ-010 SHALL have port AN  output  4  active-low digit enables.
REQ-011 SHALL have port seg  output  7  active-low segments, seg[6]=g ... seg[0]=a.

Function
REQ-012 SHALL count a prescaler 0..REFRESH_DIV-1; slot tick when count==REFRESH_DIV-1, count then returns to 0.
REQ-013 SHALL advance a 2-bit digit index on each slot tick, wrapping 3->0.
REQ-014 SHALL define frame boundary as a slot tick with index==3; frame_tick asserts that cycle.
REQ-015 SHALL map index 0/1/2/3 to AN 0111/1011/1101/1110 and nibbles [15:12]/[11:8]/[7:4]/[3:0].
REQ-016 SHALL decode nibbles to standard hex glyphs 0-F (0=1000000, 1=1111001, 8=0000000).
REQ-017 SHALL implement states IDLE, OWN0, OWN1; gnt=00/01/10 respectively.
REQ-018 SHALL evaluate state transitions and update gnt only on frame boundaries; req changes mid-frame ignored until then.
REQ-019 IDLE: if one req bit set, grant it; if both set, grant the requester not granted last (last-grant pointer).
REQ-020 OWNi: req[i]=0 -> OWN(other) if req[other], else IDLE.
REQ-021 OWNi: req[i]=1, req[other]=1, hold count >= HOLD_FRAMES -> OWN(other); otherwise stay.
REQ-022 SHALL count owned frames in a hold counter, saturating at HOLD_FRAMES, cleared on every grant change.
REQ-023 SHALL latch the post-transition owner's data at each frame boundary; display shows latched value only (no tearing).
REQ-024 In IDLE, AN SHALL be 1111 and seg 1111111 while prescaler and index keep running.

Reset
REQ-025 rst SHALL clear prescaler, index, hold counter, data latch; state IDLE; last-grant pointer favours requester 0.
REQ-026 During/after reset: gnt=00, frame_tick=0, AN=1111, seg=1111111; rst mid-frame aborts ownership the next edge.

Configuration
REQ-027 With SEG_SCAN_LZ_BLANK_EN defined, left three digits SHALL show seg=1111111 when their nibble and all more-significant nibbles are zero; rightmost digit always shown.
REQ-028 Without SEG_SCAN_LZ_BLANK_EN, all four digits SHALL always show their glyph.

Structure
REQ-029 Package seg_scan_pkg SHALL hold state enum, AN pattern constants, blank/glyph constants.
REQ-030 Combinational sub-module hex_to_seg7 (4-bit in, 7-bit active-low out) SHALL hold the glyph table.

Verification (REFRESH_DIV=4, HOLD_FRAMES=2)
REQ-031 rst held 3 cycles -> gnt=00, AN=1111, seg=1111111; first slot tick 4 cycles after release, frame_tick every 16 cycles.
REQ-032 req=01, data0=16'h1234 -> at next boundary gnt=01; AN 0111/1011/1101/1110 show 1,2,3,4, 4 cycles each.
REQ-033 Both req from IDLE after reset -> gnt=01; after 2 owned frames -> gnt=10; after 2 more -> gnt=01.
REQ-034 Owner 0 drops req mid-frame, req[1]=0 -> gnt stays 01 until boundary, then 00 and display blanks.
REQ-035 data0 changes 16'h1234->16'hABCD mid-frame -> current frame still 1234, next frame ABCD.
REQ-036 LZ_BLANK build, data0=16'h0005 -> three left digits blank, rightmost 0010010; data0=16'h0000 -> rightmost 1000000.
